// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline interlock and flush sequencer for the seven-stage core
// (IF, ID, EX, MEM1, MEM2, MEM3, WB).
//
// Load data is first forwardable from MEM3, so a load in MEM1 feeding the EX
// instruction costs two stall cycles and a load in MEM2 costs one. During a
// stall the front end (PC, IF/ID, ID/EX) holds and a NOP enters EX/MEM1.
// EX-resolved redirects flush IF/ID and ID/EX. A busy data memory freezes the
// whole pipeline and suspends this block's own state.
//
// Optional feature macro: HAZARD_PERF_EN (performance counters).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   EnRs1_ex, EnRs2_ex        EX instruction reads rs1 / rs2
//   Rs1Idx_ex, Rs2Idx_ex      EX source register indices
//   EnRegW_mem1, EnMemR_mem1  MEM1 writes a register / is a load
//   RdIdx_mem1                MEM1 destination index
//   EnRegW_mem2, EnMemR_mem2  MEM2 writes a register / is a load
//   RdIdx_mem2                MEM2 destination index
//   ex_redirect               EX requests a PC redirect
//   dmem_busy                 data memory not ready
//   stall_if/id/ex            hold PC, IF/ID, ID/EX
//   bubble_mem1               load NOP into EX/MEM1
//   flush_id, flush_ex        clear IF/ID, ID/EX
//   redirect_take             PC takes redirect target this edge
//   freeze_all                hold every pipeline register
//   lu_stall_cnt, flush_cnt   performance counters (0 without HAZARD_PERF_EN)
module hazard_ctrl #(
  parameter int RF_SIZE = 5,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EnRs1_ex,
  input  logic               EnRs2_ex,
  input  logic [RF_SIZE-1:0] Rs1Idx_ex,
  input  logic [RF_SIZE-1:0] Rs2Idx_ex,
  input  logic               EnRegW_mem1,
  input  logic               EnMemR_mem1,
  input  logic [RF_SIZE-1:0] RdIdx_mem1,
  input  logic               EnRegW_mem2,
  input  logic               EnMemR_mem2,
  input  logic [RF_SIZE-1:0] RdIdx_mem2,
  input  logic               ex_redirect,
  input  logic               dmem_busy,
  output logic               stall_if,
  output logic               stall_id,
  output logic               stall_ex,
  output logic               bubble_mem1,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               redirect_take,
  output logic               freeze_all,
  output logic [PERF_W-1:0]  lu_stall_cnt,
  output logic [PERF_W-1:0]  flush_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_t;

  state_t state;
  logic   rem;
  logic   hazard_m1;
  logic   hazard_m2;
  logic   lu_stall;
  logic   redirect;

  // A load in a MEM stage conflicts with EX when it writes a non-zero register
  // that EX actually reads.
  function automatic logic load_hazard(
    input logic               en_w,
    input logic               en_r,
    input logic [RF_SIZE-1:0] rd,
    input logic               en1,
    input logic [RF_SIZE-1:0] rs1,
    input logic               en2,
    input logic [RF_SIZE-1:0] rs2
  );
    return en_w & en_r & (rd != {RF_SIZE{1'b0}}) &
           ((en1 & (rd == rs1)) | (en2 & (rd == rs2)));
  endfunction

  // Hazard detection and priority resolution: busy > load-use stall > redirect.
  always_comb begin
    hazard_m1 = load_hazard(EnRegW_mem1, EnMemR_mem1, RdIdx_mem1,
                            EnRs1_ex, Rs1Idx_ex, EnRs2_ex, Rs2Idx_ex);
    hazard_m2 = load_hazard(EnRegW_mem2, EnMemR_mem2, RdIdx_mem2,
                            EnRs1_ex, Rs1Idx_ex, EnRs2_ex, Rs2Idx_ex);
    lu_stall  = 1'b0;
    redirect  = 1'b0;
    if (dmem_busy) begin
      lu_stall = 1'b0;
      redirect = 1'b0;
    end else begin
      // LU_WAIT stalls without looking at the inputs again.
      lu_stall = (state == LU_WAIT) | hazard_m1 | hazard_m2;
      redirect = ex_redirect & ~lu_stall;
    end
  end

  // Output decode; everything drops as soon as reset asserts.
  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    bubble_mem1   = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    redirect_take = 1'b0;
    freeze_all    = 1'b0;
    if (rst) begin
      freeze_all = 1'b0;
    end else begin
      stall_if      = lu_stall;
      stall_id      = lu_stall;
      stall_ex      = lu_stall;
      bubble_mem1   = lu_stall;
      flush_id      = redirect;
      flush_ex      = redirect;
      redirect_take = redirect;
      freeze_all    = dmem_busy;
    end
  end

  // Load-use sequencer; suspended entirely while data memory is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= 1'b0;
    end else if (!dmem_busy) begin
      case (state)
        RUN: begin
          // A MEM1 load also covers any simultaneous MEM2 load.
          if (hazard_m1) begin
            state <= LU_WAIT;
            rem   <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        LU_WAIT: begin
          if (rem) begin
            state <= RUN;
            rem   <= 1'b0;
          end else begin
            // rem should never be 0 here; reload so the wait still ends.
            rem <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          rem   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] lu_cnt;
  logic [PERF_W-1:0] fl_cnt;

  // Performance counters; lu_stall and redirect are already zero while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt <= {PERF_W{1'b0}};
      fl_cnt <= {PERF_W{1'b0}};
    end else begin
      if (lu_stall) begin
        lu_cnt <= lu_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if (redirect) begin
        fl_cnt <= fl_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign lu_stall_cnt = lu_cnt;
  assign flush_cnt    = fl_cnt;
`else
  assign lu_stall_cnt = {PERF_W{1'b0}};
  assign flush_cnt    = {PERF_W{1'b0}};
`endif

endmodule
